// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB NRZI transmit encoder.
// Line pairs are {dp, dm}.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_STUFF,
    S_EOP_SE0,
    S_EOP_J
  } state_e;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam int SYNC_BITS_DEF    = 8;
  localparam int STUFF_LEN_DEF    = 6;
  localparam int EOP_SE0_BITS_DEF = 2;

  typedef struct packed {
    logic open;
    logic emit;
    logic nrz;
    logic se0;
    logic close;
  } line_cmd_t;

endpackage

// File: rtl/usb_tx_line_drv.sv
// Line driver: NRZI level register plus registered dp/dm/oe.
// Commands are one-hot per cycle; no command holds the line.
module usb_tx_line_drv
  import usb_tx_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  line_cmd_t cmd,
  output logic      dp,
  output logic      dm,
  output logic      oe
);

  logic       lvl_q, lvl_d;
  logic [1:0] line_q, line_d;
  logic       oe_q, oe_d;
  logic       nxt;

  always_comb begin
    lvl_d  = lvl_q;
    line_d = line_q;
    oe_d   = oe_q;
    nxt    = cmd.nrz ? lvl_q : ~lvl_q;
    unique case (1'b1)
      cmd.open: begin
        lvl_d  = 1'b1;
        line_d = LINE_J;
        oe_d   = 1'b1;
      end
      cmd.emit: begin
        lvl_d  = nxt;
        line_d = nxt ? LINE_J : LINE_K;
      end
      cmd.se0: line_d = LINE_SE0;
      cmd.close: begin
        lvl_d  = 1'b1;
        line_d = LINE_J;
        oe_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q  <= 1'b1;
      line_q <= LINE_J;
      oe_q   <= 1'b0;
    end else begin
      lvl_q  <= lvl_d;
      line_q <= line_d;
      oe_q   <= oe_d;
    end
  end

  assign dp = line_q[1];
  assign dm = line_q[0];
  assign oe = oe_q;

endmodule

// File: rtl/usb_nrzi_tx.sv
// USB transmit encoder: SYNC, payload, EOP, NRZI line drive.
// Bit stuffing is built only with USB_TX_BITSTUFF_EN defined.
module usb_nrzi_tx
  import usb_tx_pkg::*;
#(
  parameter int SYNC_BITS    = SYNC_BITS_DEF,
  parameter int STUFF_LEN    = STUFF_LEN_DEF,
  parameter int EOP_SE0_BITS = EOP_SE0_BITS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic start,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic bit_last,
  output logic bit_ready,
  output logic dp,
  output logic dm,
  output logic oe,
  output logic busy,
  output logic done,
  output logic underrun
);

  localparam int MAXC =
    (SYNC_BITS > EOP_SE0_BITS) ? SYNC_BITS : EOP_SE0_BITS;
  localparam int CW = $clog2(MAXC + 1);

  if (SYNC_BITS < 2 || STUFF_LEN < 1 || EOP_SE0_BITS < 1)
  begin : g_bad_param
    $error("usb_nrzi_tx: illegal parameter value");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          und_q, und_d;
  line_cmd_t     cmd;

`ifdef USB_TX_BITSTUFF_EN
  localparam int OW = $clog2(STUFF_LEN + 1);
  logic [OW-1:0] ones_q, ones_d;
  state_e        ret_q, ret_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      und_q   <= 1'b0;
`ifdef USB_TX_BITSTUFF_EN
      ones_q  <= '0;
      ret_q   <= S_DATA;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      und_q   <= und_d;
`ifdef USB_TX_BITSTUFF_EN
      ones_q  <= ones_d;
      ret_q   <= ret_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    und_d   = 1'b0;
`ifdef USB_TX_BITSTUFF_EN
    ret_d   = ret_q;
    ones_d  = ones_q;
    if (cmd.emit)
      ones_d = cmd.nrz ? ones_q + OW'(1) : '0;
`endif
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_SYNC;
        cnt_d   = '0;
`ifdef USB_TX_BITSTUFF_EN
        ones_d  = '0;
`endif
      end
      S_SYNC: if (tick) begin
        if (cnt_q == CW'(SYNC_BITS - 1)) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: if (tick) begin
        if (!bit_valid) begin
          und_d   = 1'b1;
          state_d = S_EOP_SE0;
`ifdef USB_TX_BITSTUFF_EN
        end else if (bit_in &&
                     ones_q == OW'(STUFF_LEN - 1)) begin
          state_d = S_STUFF;
          ret_d   = bit_last ? S_EOP_SE0 : S_DATA;
`endif
        end else if (bit_last) begin
          state_d = S_EOP_SE0;
        end
      end
`ifdef USB_TX_BITSTUFF_EN
      S_STUFF: if (tick) state_d = ret_q;
`endif
      S_EOP_SE0: if (tick) begin
        if (cnt_q == CW'(EOP_SE0_BITS - 1)) begin
          state_d = S_EOP_J;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_EOP_J: if (tick) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd       = '0;
    bit_ready = 1'b0;
    unique case (state_q)
      S_IDLE: cmd.open = start;
      S_SYNC: begin
        cmd.emit = tick;
        cmd.nrz  = (cnt_q == CW'(SYNC_BITS - 1));
      end
      S_DATA: begin
        bit_ready = tick;
        cmd.emit  = tick & bit_valid;
        cmd.nrz   = bit_in;
      end
`ifdef USB_TX_BITSTUFF_EN
      S_STUFF: cmd.emit = tick;
`endif
      S_EOP_SE0: cmd.se0 = tick;
      S_EOP_J: cmd.close = tick;
      default: ;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign underrun = und_q;

  usb_tx_line_drv u_line (
    .clk  (clk),
    .rst_n(rst_n),
    .cmd  (cmd),
    .dp   (dp),
    .dm   (dm),
    .oe   (oe)
  );

endmodule

// File: tb/tb_usb_nrzi_tx.sv
// Directed bench for usb_nrzi_tx; line logs are per tick, oldest bit
// in the MSB. Expectations follow USB_TX_BITSTUFF_EN when defined.
module tb_usb_nrzi_tx;

  logic clk, rst_n, tick, start;
  logic bit_in, bit_valid, bit_last;
  logic bit_ready, dp, dm, oe, busy, done, underrun;

  int nchk = 0;
  int nerr = 0;

  usb_nrzi_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .start    (start),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .bit_last (bit_last),
    .bit_ready(bit_ready),
    .dp       (dp),
    .dm       (dm),
    .oe       (oe),
    .busy     (busy),
    .done     (done),
    .underrun (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic run_pkt(
    input  logic [15:0] pl,
    input  int          n,
    input  int          drop_at,
    input  int          tdiv,
    input  int          restart_at,
    output logic [31:0] gdp,
    output logic [31:0] gdm,
    output logic [31:0] goe,
    output logic [31:0] grdy,
    output int          nt,
    output int          ndone,
    output int          nund,
    output int          nglitch
  );
    int   idx, cyc;
    logic rdy, tk, pdp, pdm;
    bit   fin;
    gdp = '0; gdm = '0; goe = '0; grdy = '0;
    nt = 0; ndone = 0; nund = 0; nglitch = 0;
    start = 1'b1;
    tick = (tdiv == 1);
    bit_valid = 1'b0; bit_last = 1'b0; bit_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_oe", oe, 1);
    chk("start_busy", busy, 1);
    chk("start_line", {dp, dm}, 2'b10);
    pdp = dp; pdm = dm;
    idx = 0; cyc = 1; fin = 0;
    while (!fin && cyc < 400) begin
      tk = ((cyc % tdiv) == 0);
      tick = tk;
      start = (cyc == restart_at);
      bit_in = pl[idx];
      bit_last = (idx == n - 1);
      bit_valid = (idx != drop_at);
      #1;
      rdy = bit_ready;
      if (!tk && rdy) nglitch++;
      @(posedge clk); #1;
      if (tk) begin
        gdp  = {gdp[30:0], dp};
        gdm  = {gdm[30:0], dm};
        goe  = {goe[30:0], oe};
        grdy = {grdy[30:0], rdy};
        nt++;
      end else if (dp !== pdp || dm !== pdm) begin
        nglitch++;
      end
      pdp = dp; pdm = dm;
      if (done) ndone++;
      if (underrun) nund++;
      if (rdy && bit_valid) idx++;
      if (!busy) fin = 1;
      cyc++;
    end
    start = 1'b0; tick = 1'b1; bit_valid = 1'b0;
    chk("pkt_timeout", fin, 1);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("idle_line", {dp, dm, oe}, 3'b100);
    tick = 1'b0;
  endtask

  task automatic pkt(
    input string       tag,
    input logic [15:0] pl,
    input int          n,
    input int          drop_at,
    input int          tdiv,
    input int          restart_at,
    input int          ent,
    input logic [31:0] edp,
    input logic [31:0] edm,
    input logic [31:0] eoe,
    input logic [31:0] erdy,
    input int          eund
  );
    logic [31:0] gdp, gdm, goe, grdy;
    int nt, ndone, nund, ngl;
    run_pkt(pl, n, drop_at, tdiv, restart_at,
            gdp, gdm, goe, grdy, nt, ndone, nund, ngl);
    chk({tag, "_ticks"}, nt, ent);
    chk({tag, "_dp"}, gdp, edp);
    chk({tag, "_dm"}, gdm, edm);
    chk({tag, "_oe"}, goe, eoe);
    chk({tag, "_rdy"}, grdy, erdy);
    chk({tag, "_done"}, ndone, 1);
    chk({tag, "_undr"}, nund, eund);
    chk({tag, "_glitch"}, ngl, 0);
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b1; start = 1'b0;
    bit_in = 1'b1; bit_valid = 1'b1; bit_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_line", {dp, dm, oe}, 3'b100);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {done, underrun}, 2'b00);
    chk("rst_ready", bit_ready, 0);
    #3 rst_n = 1'b1;

    pkt("a5", 16'h00A5, 8, -1, 1, -1, 19,
        32'b0101010001101100001, 32'b1010101110010011000,
        32'h7FFFE, 32'b0000000011111111000, 0);

`ifdef USB_TX_BITSTUFF_EN
    pkt("run7", 16'h007F, 8, -1, 1, -1, 20,
        32'b01010100000001110001, 32'b10101011111110001000,
        32'hFFFFE, 32'b00000000111110111000, 0);
    pkt("last6", 16'h001F, 5, -1, 1, -1, 17,
        32'b01010100000001001, 32'b10101011111110000,
        32'h1FFFE, 32'b00000000111110000, 0);
`else
    pkt("run7", 16'h007F, 8, -1, 1, -1, 19,
        32'b0101010000000001001, 32'b1010101111111110000,
        32'h7FFFE, 32'b0000000011111111000, 0);
    pkt("last6", 16'h001F, 5, -1, 1, -1, 16,
        32'b0101010000000001, 32'b1010101111111000,
        32'hFFFE, 32'b0000000011111000, 0);
`endif

    pkt("undr", 16'h00A5, 8, 3, 1, -1, 15,
        32'b010101000111001, 32'b101010111000000,
        32'h7FFE, 32'b000000001111000, 1);

    pkt("tdiv4", 16'h00A5, 8, -1, 4, 10, 19,
        32'b0101010001101100001, 32'b1010101110010011000,
        32'h7FFFE, 32'b0000000011111111000, 0);

    start = 1'b1; tick = 1'b1;
    bit_in = 1'b1; bit_valid = 1'b1; bit_last = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_line", {dp, dm, oe}, 3'b100);
    chk("arst_busy", busy, 0);
    chk("arst_ready", bit_ready, 0);
    #1 rst_n = 1'b1;

    pkt("post", 16'h00A5, 8, -1, 1, -1, 19,
        32'b0101010001101100001, 32'b1010101110010011000,
        32'h7FFFE, 32'b0000000011111111000, 0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
